// File: rtl/psum_drain_serializer.sv
// Snapshot buffer and serializer for the sparse MAC row's partial sums.
// Each psum is shaped on the way out: optional ReLU, then signed saturation down to out_bw.
module psum_drain_serializer #(
    parameter int psum_bw = 20,
    parameter int col     = 4,
    parameter int out_bw  = 16,
    parameter int DEPTH   = 2,
    parameter int RELU_EN = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  capture,
    input  logic [col*psum_bw-1:0]                in_psum_flat,
    output logic                                  cap_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [out_bw-1:0]                     out_data,
    output logic [((col > 1) ? $clog2(col) : 1)-1:0] out_index,
    output logic                                  out_last,
    output logic                                  overflow_err,
    output logic                                  sat_err
);

    localparam int IDX_W = (col > 1) ? $clog2(col) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(col - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic signed [psum_bw-1:0] SAT_MAX =
        {{(psum_bw - out_bw + 1){1'b0}}, {(out_bw - 1){1'b1}}};
    localparam logic signed [psum_bw-1:0] SAT_MIN =
        {{(psum_bw - out_bw + 1){1'b1}}, {(out_bw - 1){1'b0}}};

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state;
    logic [col*psum_bw-1:0] buf_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       rd_ptr_inc;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic                   out_sat;

    logic                   hs;
    logic                   pop;
    logic                   push;
    logic [col*psum_bw-1:0] src_flat;
    logic [IDX_W-1:0]       src_idx;
    logic [out_bw:0]        shaped;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (DEPTH == 1) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    // Returns {saturated, value}.
    function automatic logic [out_bw:0] shape(input logic [psum_bw-1:0] raw);
        logic signed [psum_bw-1:0] v;
        v = signed'(raw);
        if (RELU_EN != 0 && v < 0) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            return {1'b1, SAT_MAX[out_bw-1:0]};
        end
        if (v < SAT_MIN) begin
            return {1'b1, SAT_MIN[out_bw-1:0]};
        end
        return {1'b0, v[out_bw-1:0]};
    endfunction

    assign cap_ready = (count < DEPTH_C);

    // The source mux picks whatever word the output register must hold after this edge.
    // A last-word pop with a single entry left and a capture arriving takes the word straight
    // from the input so back-to-back snapshots leave no gap.
    always_comb begin
        hs         = out_valid & out_ready;
        pop        = hs & out_last;
        push       = capture & cap_ready;
        rd_ptr_inc = ptr_inc(rd_ptr);
        src_flat   = buf_mem[rd_ptr];
        src_idx    = '0;
        if (state == SEND && hs) begin
            if (!out_last) begin
                src_idx = out_index + IDX_W'(1);
            end else if (count > CNT_ONE) begin
                src_flat = buf_mem[rd_ptr_inc];
            end else begin
                src_flat = in_psum_flat;
            end
        end
        shaped = shape(src_flat[int'(src_idx)*psum_bw +: psum_bw]);
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_mem[wr_ptr] <= in_psum_flat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_index    <= '0;
            out_last     <= 1'b0;
            out_sat      <= 1'b0;
            overflow_err <= 1'b0;
            sat_err      <= 1'b0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (capture && !cap_ready) begin
                overflow_err <= 1'b1;
            end
            if (hs && out_sat) begin
                sat_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        out_valid <= 1'b1;
                        out_data  <= shaped[out_bw-1:0];
                        out_sat   <= shaped[out_bw];
                        out_index <= src_idx;
                        out_last  <= (src_idx == IDX_LAST);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (out_last) begin
                            rd_ptr <= rd_ptr_inc;
                        end
                        if (!out_last || count > CNT_ONE || push) begin
                            out_valid <= 1'b1;
                            out_data  <= shaped[out_bw-1:0];
                            out_sat   <= shaped[out_bw];
                            out_index <= src_idx;
                            out_last  <= (src_idx == IDX_LAST);
                        end else begin
                            out_valid <= 1'b0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                            out_sat   <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_drain_serializer.sv
// Scoreboard bench: two serializers (ReLU on / off) share stimulus; a monitor checks every transfer.
module tb_psum_drain_serializer;

    localparam int PB = 20;
    localparam int NC = 4;
    localparam int OB = 16;

    logic              clk;
    logic              reset;
    logic              capture;
    logic [NC*PB-1:0]  in_psum_flat;
    logic              out_ready;

    logic              r_cap_ready, r_valid, r_last, r_ovf, r_sat;
    logic [OB-1:0]     r_data;
    logic [1:0]        r_index;
    logic              l_cap_ready, l_valid, l_last, l_ovf, l_sat;
    logic [OB-1:0]     l_data;
    logic [1:0]        l_index;

    psum_drain_serializer #(.psum_bw(PB), .col(NC), .out_bw(OB), .DEPTH(2), .RELU_EN(1)) u_relu (
        .clk(clk), .reset(reset), .capture(capture), .in_psum_flat(in_psum_flat),
        .cap_ready(r_cap_ready), .out_valid(r_valid), .out_ready(out_ready),
        .out_data(r_data), .out_index(r_index), .out_last(r_last),
        .overflow_err(r_ovf), .sat_err(r_sat)
    );

    psum_drain_serializer #(.psum_bw(PB), .col(NC), .out_bw(OB), .DEPTH(2), .RELU_EN(0)) u_lin (
        .clk(clk), .reset(reset), .capture(capture), .in_psum_flat(in_psum_flat),
        .cap_ready(l_cap_ready), .out_valid(l_valid), .out_ready(out_ready),
        .out_data(l_data), .out_index(l_index), .out_last(l_last),
        .overflow_err(l_ovf), .sat_err(l_sat)
    );

    typedef struct {
        int data;
        int idx;
    } exp_t;

    exp_t q_r[$];
    exp_t q_l[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    // psums p0..p3 and hand-computed outputs for ReLU on / off
    int vec_p[6][4];
    int exp_r[6][4];
    int exp_l[6][4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_one(input string name, input logic [OB-1:0] d, input logic [1:0] ix,
                           input logic lst, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got word %0d idx %0d expected no word", name,
                     int'($signed(d)), ix);
        end else begin
            e = q.pop_front();
            chk({name, "_data"}, int'($signed(d)), e.data);
            chk({name, "_index"}, int'(ix), e.idx);
            chk({name, "_last"}, int'(lst), int'(e.idx == NC - 1));
        end
    endtask

    // Inputs change at negedge, so the handshake for the coming posedge is stable here.
    always begin
        @(negedge clk);
        #2;
        if (!reset && out_ready) begin
            if (r_valid) begin
                mon_one("relu", r_data, r_index, r_last, q_r);
                pops++;
            end
            if (l_valid) begin
                mon_one("lin", l_data, l_index, l_last, q_l);
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        capture   = 1'b0;
        out_ready = 1'b0;
        in_psum_flat = '0;
        @(negedge clk);
        @(negedge clk);
        q_r.delete();
        q_l.delete();
        reset = 1'b0;
    endtask

    task automatic set_vec(input int v, input bit accept);
        exp_t e;
        for (int k = 0; k < NC; k++) begin
            in_psum_flat[k*PB +: PB] = PB'(vec_p[v][k]);
            if (accept) begin
                e.idx  = k;
                e.data = exp_r[v][k];
                q_r.push_back(e);
                e.data = exp_l[v][k];
                q_l.push_back(e);
            end
        end
        capture = 1'b1;
    endtask

    task automatic do_capture(input int v, input bit accept);
        set_vec(v, accept);
        @(negedge clk);
        capture = 1'b0;
    endtask

    task automatic drain_wait(input string name, input int budget);
        int n;
        n = 0;
        while ((q_r.size() != 0 || q_l.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, q_r.size() + q_l.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int p0;
        vec_p = '{'{524287, 5, -7, 40}, '{-32768, -32769, 32767, -1},
                  '{100, -100, 32768, -524288}, '{1, 2, 3, 4},
                  '{-1, 16, -32767, 65536}, '{7, 8, 9, 10}};
        exp_r = '{'{32767, 5, 0, 40}, '{0, 0, 32767, 0},
                  '{100, 0, 32767, 0}, '{1, 2, 3, 4},
                  '{0, 16, 0, 32767}, '{7, 8, 9, 10}};
        exp_l = '{'{32767, 5, -7, 40}, '{-32768, -32768, 32767, -1},
                  '{100, -100, 32767, -32768}, '{1, 2, 3, 4},
                  '{-1, 16, -32767, 32767}, '{7, 8, 9, 10}};

        // reset values
        do_reset();
        chk("rst_cap_ready", int'(r_cap_ready), 1);
        chk("rst_valid", int'(r_valid), 0);
        chk("rst_data", int'(r_data), 0);
        chk("rst_index", int'(r_index), 0);
        chk("rst_last", int'(r_last), 0);
        chk("rst_ovf", int'(r_ovf), 0);
        chk("rst_sat", int'(r_sat), 0);

        // 1: saturating positive and ReLU
        out_ready = 1'b1;
        do_capture(0, 1'b1);
        chk("t1_latency_valid", int'(r_valid), 0);
        drain_wait("t1", 20);
        chk("t1_valid_after", int'(r_valid), 0);
        chk("t1_relu_sat_err", int'(r_sat), 1);
        chk("t1_lin_sat_err", int'(l_sat), 1);

        // 2: negative saturation without ReLU, no bubbles
        do_reset();
        out_ready = 1'b1;
        do_capture(1, 1'b1);
        chk("t2_latency_valid", int'(l_valid), 0);
        for (int i = 0; i < NC; i++) begin
            @(negedge clk);
            chk("t2_no_bubble", int'(l_valid), 1);
        end
        @(negedge clk);
        chk("t2_valid_drop", int'(l_valid), 0);
        chk("t2_lin_sat_err", int'(l_sat), 1);
        chk("t2_relu_sat_err", int'(r_sat), 0);
        drain_wait("t2", 4);

        // 3: backpressure holds idx0 stable
        do_reset();
        do_capture(3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", int'(r_valid), 1);
            chk("t3_hold_data", int'($signed(r_data)), 1);
            chk("t3_hold_index", int'(r_index), 0);
        end
        p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < NC; i++) @(negedge clk);
        chk("t3_words_in_4", pops - p0, NC);
        chk("t3_valid_after", int'(r_valid), 0);
        drain_wait("t3", 4);

        // 4: overflow on third capture with DEPTH=2
        do_reset();
        chk("t4_cap_ready_0", int'(r_cap_ready), 1);
        do_capture(4, 1'b1);
        chk("t4_cap_ready_1", int'(r_cap_ready), 1);
        do_capture(5, 1'b1);
        chk("t4_cap_ready_2", int'(r_cap_ready), 0);
        chk("t4_lin_cap_ready_2", int'(l_cap_ready), 0);
        do_capture(2, 1'b0);
        chk("t4_overflow", int'(r_ovf), 1);
        chk("t4_lin_overflow", int'(l_ovf), 1);
        p0 = pops;
        out_ready = 1'b1;
        drain_wait("t4", 30);
        chk("t4_word_count", pops - p0, 2 * NC);
        chk("t4_valid_after", int'(r_valid), 0);

        // 5: capture on the last-word handshake
        do_reset();
        out_ready = 1'b1;
        do_capture(3, 1'b1);
        n = 0;
        while (!(r_valid && r_index == 2'd3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_last", int'(r_valid && r_index == 2'd3), 1);
        do_capture(5, 1'b1);
        chk("t5_no_gap_valid", int'(r_valid), 1);
        chk("t5_no_gap_index", int'(r_index), 0);
        chk("t5_no_gap_data", int'($signed(r_data)), 7);
        chk("t5_cap_ready", int'(r_cap_ready), 1);
        drain_wait("t5", 20);

        // 6: reset in the middle of a drain
        do_reset();
        do_capture(0, 1'b1);
        do_capture(3, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_at_idx2", int'(r_index), 2);
        chk("t6_pending", q_r.size(), 6);
        reset     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        q_r.delete();
        q_l.delete();
        chk("t6_valid", int'(r_valid), 0);
        chk("t6_cap_ready", int'(r_cap_ready), 1);
        chk("t6_sat_err", int'(r_sat), 0);
        chk("t6_lin_sat_err", int'(l_sat), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_words", int'(r_valid | l_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
